// File: rtl/sdram_port_arb.sv
// Round-robin arbiter granting one of CH_NUM request channels access to a single SDRAM controller port.
// Define SDRAM_ARB_TIMEOUT_EN to build the REQ/XFER watchdog (to_pulse/to_err); otherwise both are tied low.
module sdram_port_arb #(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned CH_W   = 2,
    parameter int unsigned TO_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] ch_en,
    input  logic [CH_NUM-1:0] ch_req,
    output logic [CH_NUM-1:0] ch_ack,
    output logic              mem_req,
    input  logic              mem_req_ack,
    input  logic              mem_done,
    output logic              grant_vld,
    output logic [CH_W-1:0]   grant_idx,
    output logic              to_pulse,
    output logic              to_err,
    input  logic              err_clr
);
    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   last_idx_q, last_idx_d;
    logic [CH_W-1:0]   grant_idx_q, grant_idx_d;
    logic [CH_NUM-1:0] ch_ack_q, ch_ack_d;
    logic              mem_req_q, mem_req_d;
    logic              grant_vld_q, grant_vld_d;

    logic [CH_NUM-1:0] elig;
    logic              any_elig;
    logic [CH_W-1:0]   pick;
    logic              timeout;

    // Slot visited at search offset ofs, starting just after base and wrapping at CH_NUM.
    function automatic logic [CH_W-1:0] rr_slot(input logic [CH_W-1:0] base, input int unsigned ofs);
        int unsigned s;
        s = 32'(base) + 1 + ofs;
        if (s >= CH_NUM) s = s - CH_NUM;
        return CH_W'(s);
    endfunction

    assign elig = ch_req & ch_en;

    always_comb begin
        pick     = last_idx_q;
        any_elig = 1'b0;
        for (int unsigned k = 0; k < CH_NUM; k++) begin
            if (!any_elig && elig[rr_slot(last_idx_q, k)]) begin
                any_elig = 1'b1;
                pick     = rr_slot(last_idx_q, k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_idx_d  = last_idx_q;
        grant_idx_d = grant_idx_q;
        ch_ack_d    = '0;
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d     = REQ;
                    grant_idx_d = pick;
                end
            end
            REQ: begin
                // Watchdog first, then ack beats a same-cycle enable drop.
                if (timeout) begin
                    state_d    = IDLE;
                    last_idx_d = grant_idx_q;
                end else if (mem_req_ack) begin
                    state_d               = XFER;
                    ch_ack_d[grant_idx_q] = 1'b1;
                end else if (!ch_en[grant_idx_q]) begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (timeout || mem_done) begin
                    state_d    = IDLE;
                    last_idx_d = grant_idx_q;
                end
            end
            default: state_d = IDLE;
        endcase
        mem_req_d   = (state_d == REQ);
        grant_vld_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_idx_q  <= CH_W'(CH_NUM - 1);
            grant_idx_q <= '0;
            ch_ack_q    <= '0;
            mem_req_q   <= 1'b0;
            grant_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_idx_q  <= last_idx_d;
            grant_idx_q <= grant_idx_d;
            ch_ack_q    <= ch_ack_d;
            mem_req_q   <= mem_req_d;
            grant_vld_q <= grant_vld_d;
        end
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        to_pulse_q, to_pulse_d;
    logic        to_err_q, to_err_d;

    assign timeout = (state_q != IDLE) && ((32'(cnt_q) + 1) == TO_CYC);

    always_comb begin
        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q != IDLE)
            cnt_d = cnt_q + 16'd1;
        else
            cnt_d = cnt_q;
        to_pulse_d = timeout;
        to_err_d   = timeout ? 1'b1 : (err_clr ? 1'b0 : to_err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            to_pulse_q <= 1'b0;
            to_err_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            to_pulse_q <= to_pulse_d;
            to_err_q   <= to_err_d;
        end
    end

    assign to_pulse = to_pulse_q;
    assign to_err   = to_err_q;
`else
    logic [16:0] unused_cfg;
    assign unused_cfg = {err_clr, 16'(TO_CYC)};
    assign timeout    = 1'b0;
    assign to_pulse   = 1'b0;
    assign to_err     = 1'b0;
`endif

    assign ch_ack    = ch_ack_q;
    assign mem_req   = mem_req_q;
    assign grant_vld = grant_vld_q;
    assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Randomized bench for sdram_port_arb against a transaction-level round-robin model.
// Covers the SDRAM_ARB_TIMEOUT_EN watchdog when that macro is defined for the build.
module tb_sdram_port_arb;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ch_en, ch_req, ch_ack;
    logic       mem_req, mem_req_ack, mem_done, grant_vld;
    logic [1:0] grant_idx;
    logic       to_pulse, to_err, err_clr;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [3:0] pend;
    logic [3:0] en_m;
    int         last_m;
    bit         mon_flags;
    logic       exp_err;

    sdram_port_arb #(.CH_NUM(4), .CH_W(2), .TO_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .ch_req(ch_req), .ch_ack(ch_ack),
        .mem_req(mem_req), .mem_req_ack(mem_req_ack), .mem_done(mem_done),
        .grant_vld(grant_vld), .grant_idx(grant_idx), .to_pulse(to_pulse),
        .to_err(to_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner: first eligible channel after the last owner, wrapping around.
    function automatic int rr_pick(input int last, input logic [3:0] el);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (el[c[1:0]]) return c;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (mon_flags) begin
            check_eq("to_pulse_quiet", 32'(to_pulse), 0);
            check_eq("to_err_level", 32'(to_err), 32'(exp_err));
        end
    endtask

    // mode 0: normal, 1: enable drops in REQ without ack, 2: enable drop and ack together.
    task automatic run_txn(input int ack_dly, input int done_dly, input int mode, output int granted);
        int w;
        granted     = -1;
        ch_req      = pend;
        ch_en       = en_m;
        mem_req_ack = 1'($urandom_range(0, 1));
        mem_done    = 1'($urandom_range(0, 1));
        w = rr_pick(last_m, pend & en_m);
        step();
        mem_req_ack = 1'b0;
        mem_done    = 1'b0;
        if (w < 0) begin
            check_eq("idle_no_req", 32'(mem_req), 0);
            check_eq("idle_no_vld", 32'(grant_vld), 0);
            return;
        end
        check_eq("mem_req_rise", 32'(mem_req), 1);
        check_eq("grant_idx", 32'(grant_idx), 32'(w));
        check_eq("ack_in_req", 32'(ch_ack), 0);
        for (int i = 0; i < ack_dly; i++) begin
            mem_done = 1'($urandom_range(0, 3) == 0);
            step();
            mem_done = 1'b0;
            check_eq("req_hold", 32'(mem_req), 1);
            check_eq("req_vld", 32'(grant_vld), 1);
            check_eq("req_no_ack", 32'(ch_ack), 0);
        end
        if (mode == 1) begin
            en_m[w[1:0]] = 1'b0;
            ch_en = en_m;
            step();
            check_eq("abort_vld", 32'(grant_vld), 0);
            check_eq("abort_req", 32'(mem_req), 0);
            check_eq("abort_no_ack", 32'(ch_ack), 0);
            return;
        end
        if (mode == 2) begin
            en_m[w[1:0]] = 1'b0;
            ch_en = en_m;
        end
        mem_req_ack = 1'b1;
        step();
        mem_req_ack = 1'b0;
        check_eq("ch_ack_pulse", 32'(ch_ack), 32'(1) << w);
        check_eq("xfer_req_low", 32'(mem_req), 0);
        check_eq("xfer_vld", 32'(grant_vld), 1);
        pend[w[1:0]] = 1'b0;
        granted = w;
        for (int i = 0; i < done_dly; i++) begin
            ch_en       = 4'($urandom_range(0, 15));
            ch_req      = 4'($urandom_range(0, 15));
            mem_req_ack = 1'($urandom_range(0, 1));
            step();
            check_eq("xfer_ack_low", 32'(ch_ack), 0);
            check_eq("xfer_hold", 32'(grant_vld), 1);
            check_eq("xfer_idx", 32'(grant_idx), 32'(w));
        end
        ch_req      = pend;
        ch_en       = en_m;
        mem_req_ack = 1'b0;
        mem_done    = 1'b1;
        step();
        mem_done = 1'b0;
        check_eq("done_idle", 32'(grant_vld), 0);
        check_eq("done_no_req", 32'(mem_req), 0);
        check_eq("done_no_ack", 32'(ch_ack), 0);
        check_eq("grant_hold", 32'(grant_idx), 32'(w));
        last_m = w;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: bench did not complete in time");
        $fatal(1, "bench stalled");
    end

    initial begin
        int g;
        int w;
        rst_n = 1'b0; ch_en = '0; ch_req = '0; mem_req_ack = 1'b0; mem_done = 1'b0; err_clr = 1'b0;
        pend = '0; en_m = '0; last_m = N - 1; mon_flags = 1'b1; exp_err = 1'b0;
        #3;
        check_eq("rst_ack", 32'(ch_ack), 0);
        check_eq("rst_mem_req", 32'(mem_req), 0);
        check_eq("rst_vld", 32'(grant_vld), 0);
        check_eq("rst_idx", 32'(grant_idx), 0);
        check_eq("rst_to_pulse", 32'(to_pulse), 0);
        check_eq("rst_to_err", 32'(to_err), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Two requesters 0 and 2.
        pend = 4'b0101; en_m = 4'hF;
        run_txn(2, 2, 0, g); check_eq("pair_first", 32'(g), 0);
        run_txn(2, 2, 0, g); check_eq("pair_second", 32'(g), 2);

        // Enable drop on ch3 in REQ, then drop coinciding with the ack.
        pend = 4'b1000; en_m = 4'hF;
        run_txn(2, 1, 1, g); check_eq("drop_no_grant", 32'(g), -1);
        en_m = 4'hF;
        run_txn(1, 1, 2, g); check_eq("drop_ack_wins", 32'(g), 3);

        // Disabled channel never reaches the controller.
        pend = 4'b0010; en_m = 4'b1101; ch_req = pend; ch_en = en_m;
        for (int i = 0; i < 100; i++) begin
            step();
            check_eq("masked_req", 32'(mem_req), 0);
        end

        for (int t = 0; t < 300; t++) begin
            int mode;
            pend   |= 4'($urandom_range(0, 15));
            en_m    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) en_m |= pend;
            err_clr = 1'($urandom_range(0, 1));
            mode    = $urandom_range(0, 5);
            run_txn($urandom_range(0, 4), $urandom_range(0, 4),
                    (mode == 4) ? 1 : ((mode == 5) ? 2 : 0), g);
        end
        err_clr = 1'b0;

        // Reset in the middle of a burst, then everyone requesting.
        pend = 4'hF; en_m = 4'hF; ch_req = pend; ch_en = en_m;
        step();
        mem_req_ack = 1'b1;
        step();
        mem_req_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("midx_rst_ack", 32'(ch_ack), 0);
        check_eq("midx_rst_req", 32'(mem_req), 0);
        check_eq("midx_rst_vld", 32'(grant_vld), 0);
        check_eq("midx_rst_idx", 32'(grant_idx), 0);
        check_eq("midx_rst_flags", 32'({to_pulse, to_err}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        last_m = N - 1;
        for (int k = 0; k < 5; k++) begin
            pend = 4'hF; en_m = 4'hF;
            run_txn(1, 1, 0, g);
            check_eq("rr_order", 32'(g), 32'(k % N));
        end

`ifdef SDRAM_ARB_TIMEOUT_EN
        mon_flags = 1'b0;
        pend = 4'b1100; en_m = 4'hF; ch_req = pend; ch_en = en_m; err_clr = 1'b0;
        w = rr_pick(last_m, pend & en_m);
        step();
        check_eq("to_mem_req", 32'(mem_req), 1);
        check_eq("to_owner", 32'(grant_idx), 32'(w));
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) err_clr = 1'b1;
            step();
            if (k < 8) begin
                check_eq("to_wait_pulse", 32'(to_pulse), 0);
                check_eq("to_wait_req", 32'(mem_req), 1);
            end else begin
                check_eq("to_fire_pulse", 32'(to_pulse), 1);
                check_eq("to_fire_err", 32'(to_err), 1);
                check_eq("to_fire_idle", 32'(grant_vld), 0);
                check_eq("to_fire_ack", 32'(ch_ack), 0);
            end
        end
        last_m  = w;
        err_clr = 1'b0;
        w = rr_pick(last_m, pend & en_m);
        step();
        check_eq("to_next_owner", 32'(grant_idx), 32'(w));
        check_eq("to_next_vld", 32'(grant_vld), 1);
        check_eq("to_err_sticky", 32'(to_err), 1);
        check_eq("to_pulse_once", 32'(to_pulse), 0);
        err_clr = 1'b1; mem_req_ack = 1'b1;
        step();
        err_clr = 1'b0; mem_req_ack = 1'b0;
        check_eq("to_err_cleared", 32'(to_err), 0);
        check_eq("to_next_ack", 32'(ch_ack), 32'(1) << w);
        pend[w[1:0]] = 1'b0; pend = '0; ch_req = pend;
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        check_eq("to_done_idle", 32'(grant_vld), 0);
        last_m = w;
        exp_err = 1'b0; mon_flags = 1'b1;
`else
        w = 0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_eq("flags_tied_low", 32'({to_pulse, to_err}), 32'(w));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
